obi_mem_responder: RTL and testbench
====================================

Name: obi_mem_responder

Overview:
- Synthesizable, parametrised memory-side responder for the core's req/gnt/rvalid instruction or data port. Replaces the always-granted, always-valid tie-offs with a real memory model.
- Adds configurable grant wait states, fixed read/write response latency, an outstanding-transaction limit, byte-enabled writes, out-of-range error reporting and a backdoor preload port.
- One instance per core port (instr, data); sits between the core and the bench.

Parameters:
- ADDR_WIDTH, 32, request address width.
- DATA_WIDTH, 32, data width; multiple of 8. BE width = DATA_WIDTH/8.
- MEM_DEPTH, 1024, number of DATA_WIDTH-wide words.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- GNT_LATENCY, 0, wait cycles from first req_i to gnt_o (0..15).
- RSP_LATENCY, 1, cycles from grant cycle to rvalid_o (1..8).
- MAX_OUTSTANDING, 2, maximum granted but unanswered transactions (1..8).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  master request; master holds addr/we/be/wdata stable until gnt_o.
- addr_i  in  ADDR_WIDTH  byte address.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  DATA_WIDTH/8  byte enables.
- wdata_i  in  DATA_WIDTH  write data.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid, one cycle per transaction.
- rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors.
- err_o  out  1  qualified by rvalid_o; address out of range.
- bd_we_i  in  1  backdoor write strobe (full word, no handshake).
- bd_addr_i  in  ADDR_WIDTH  backdoor byte address.
- bd_wdata_i  in  DATA_WIDTH  backdoor data.

Behaviour:
- Index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). In range iff addr >= BASE_ADDR and index < MEM_DEPTH. Low address bits are ignored.
- Grant FSM states: IDLE, WAIT.
  - IDLE, req_i=1, GNT_LATENCY=0, outstanding < MAX: gnt_o=1 combinationally in the same cycle; stay in IDLE.
  - IDLE, req_i=1, GNT_LATENCY>0: go to WAIT and load wcnt = GNT_LATENCY-1.
  - WAIT, wcnt != 0: decrement wcnt.
  - WAIT, wcnt = 0: gnt_o=1 if outstanding < MAX, then return to IDLE. Otherwise hold in WAIT with gnt_o=0 until a slot frees.
  - req_i dropping before grant is a protocol violation; the FSM returns to IDLE (no assertion is required).
- Grant cycle actions (handshake = req_i & gnt_o):
  - Write in range: memory bytes with be_i=1 are updated at the clock edge.
  - Read in range: the word is sampled at the grant cycle, so read-after-write ordering is preserved.
  - Out of range: no memory access; the response carries err=1 and rdata=0.
- Response pipeline: in-order delay line of depth RSP_LATENCY carrying {valid, err, rdata}.
  - Grant at cycle t gives rvalid_o=1 at cycle t+RSP_LATENCY.
  - Back-to-back grants give back-to-back rvalids.
- Outstanding counter (0..MAX_OUTSTANDING):
  - +1 on grant, -1 on rvalid_o; simultaneous grant and rvalid leave it unchanged.
  - gnt_o is never asserted while count == MAX_OUTSTANDING, except when rvalid_o is in the same cycle (the slot frees).
- Backdoor port: bd_we_i writes the full word at the edge; out of range is ignored. If the backdoor and a bus write hit the same word in the same cycle, the bus write wins.
- Reset (rst_i=1 at an edge):
  - FSM to IDLE, wcnt=0, outstanding=0, delay line cleared; in-flight responses are dropped.
  - Outputs: gnt_o=0 (forced low while rst_i=1), rvalid_o=0, rdata_o=0, err_o=0.
  - Memory array contents are not reset, so backdoor preload survives reset.

Optional Feature:
- Macro: OBI_MEM_RANDOM_STALL_EN.
- Defined:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - A grant that would otherwise occur is suppressed when lfsr[1:0]==2'b00. The FSM stays in its current state and retries next cycle.
  - Ordering and latency from the grant cycle are unchanged.
- Undefined: no LFSR logic; grant timing is fully deterministic per the FSM.

Test Plan:
- Default params. Backdoor word 0 = 32'hDEAD_BEEF. Read addr 0 -> gnt_o in the req cycle; rvalid_o next cycle; rdata_o=32'hDEAD_BEEF, err_o=0.
- Write addr 4, wdata 32'h1122_3344, be 4'b0101, over prior 32'hFFFF_FFFF; then read addr 4 -> rdata_o=32'hFF22_FF44.
- GNT_LATENCY=3, RSP_LATENCY=2. Read with req at cycle 0 -> gnt_o at cycle 3; rvalid_o at cycle 5.
- MAX_OUTSTANDING=2, RSP_LATENCY=4, req held continuously:
  - grants at cycles 0 and 1; no grant at cycles 2-3; rvalid at cycle 4 with a grant in the same cycle.
  - outstanding never exceeds 2.
- Read addr 4*MEM_DEPTH (32'h1000) -> rvalid_o=1, err_o=1, rdata_o=0. A write to the same address leaves memory unchanged.
- Two reads granted; rst_i pulsed for 1 cycle before either rvalid -> no rvalid_o afterwards, outstanding=0. A later read still returns the preloaded data.

Source files
------------

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: memory-side responder for a req/gnt/rvalid core port.
// Grant wait states, fixed response latency, outstanding limit, byte-enabled
// writes, out-of-range error responses and a backdoor preload port.
// Optional: define OBI_MEM_RANDOM_STALL_EN to randomly suppress grants via a
// 16-bit LFSR; without it grant timing is fully deterministic.
module obi_mem_responder #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           MEM_DEPTH       = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int unsigned           GNT_LATENCY     = 0,
  parameter int unsigned           RSP_LATENCY     = 1,
  parameter int unsigned           MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  input  logic                    bd_we_i,
  input  logic [ADDR_WIDTH-1:0]   bd_addr_i,
  input  logic [DATA_WIDTH-1:0]   bd_wdata_i
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS = (BE_WIDTH > 1) ? $clog2(BE_WIDTH) : 0;
  localparam int unsigned IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]      MAX_C     = CNT_W'(MAX_OUTSTANDING);
  localparam logic [3:0]            WCNT_INIT = 4'((GNT_LATENCY > 0) ? GNT_LATENCY - 1 : 0);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  slot_free;
  logic                  stall;
  logic                  hs;
  logic                  bus_wr;
  logic                  bd_ok;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [RSP_LATENCY-1:0] vld_q;
  logic [RSP_LATENCY-1:0] err_q;
  logic [DATA_WIDTH-1:0]  dat_q [RSP_LATENCY];

  // Address decode; the extra MSB of the difference is the borrow (addr below base).
  logic [ADDR_WIDTH:0]   bus_diff, bd_diff;
  logic [ADDR_WIDTH-1:0] bus_word, bd_word;
  logic [IDX_W-1:0]      bus_idx, bd_idx;
  logic                  bus_hit, bd_hit;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign bus_diff = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign bd_diff  = {1'b0, bd_addr_i} - {1'b0, BASE_ADDR};
  assign bus_word = bus_diff[ADDR_WIDTH-1:0] >> OFF_BITS;
  assign bd_word  = bd_diff[ADDR_WIDTH-1:0] >> OFF_BITS;
  assign bus_hit  = !bus_diff[ADDR_WIDTH] && (bus_word < DEPTH_A);
  assign bd_hit   = !bd_diff[ADDR_WIDTH] && (bd_word < DEPTH_A);
  assign bus_idx  = bus_word[IDX_W-1:0];
  assign bd_idx   = bd_word[IDX_W-1:0];

  assign hs        = req_i & gnt_o;
  assign bus_wr    = hs & we_i & bus_hit;
  // A bus write to the same word in the same cycle takes precedence.
  assign bd_ok     = bd_we_i & bd_hit & ~(bus_wr && (bd_idx == bus_idx));
  assign slot_free = (cnt_q < MAX_C) || rvalid_o;
  // Read data is sampled in the grant cycle so earlier writes are visible.
  assign rsp_data  = (bus_hit && !we_i) ? mem_q[bus_idx] : '0;

`ifdef OBI_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign stall   = (lfsr_q[1:0] == 2'b00);

  // Fibonacci LFSR (taps 16,14,13,11), free running.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  assign stall = 1'b0;
`endif

  // Grant FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Grant FSM next state: count wait states, hold in StWait until a slot frees.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_i && (GNT_LATENCY != 0)) begin
          state_d = StWait;
          wcnt_d  = WCNT_INIT;
        end
      end
      StWait: begin
        if (!req_i) begin
          state_d = StIdle;
          wcnt_d  = '0;
        end else if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else if (gnt_o) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        wcnt_d  = '0;
      end
    endcase
  end

  // Grant FSM output: grant once wait states are done and a slot is available.
  always_comb begin
    gnt_o = 1'b0;
    if (!rst_i && req_i && slot_free && !stall) begin
      unique case (state_q)
        StIdle:  gnt_o = (GNT_LATENCY == 0);
        StWait:  gnt_o = (wcnt_q == '0);
        default: gnt_o = 1'b0;
      endcase
    end
  end

  // Outstanding counter next state.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({gnt_o, rvalid_o})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Outstanding counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // In-order response delay line; reset drops in-flight responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < RSP_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= hs;
      err_q[0] <= hs & ~bus_hit;
      dat_q[0] <= hs ? rsp_data : '0;
      for (int i = 1; i < RSP_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rvalid_o = vld_q[RSP_LATENCY-1];
  assign err_o    = err_q[RSP_LATENCY-1];
  assign rdata_o  = dat_q[RSP_LATENCY-1];

  // Memory array: backdoor full-word writes and byte-enabled bus writes; never reset.
  always_ff @(posedge clk_i) begin
    if (bd_ok) begin
      mem_q[bd_idx] <= bd_wdata_i;
    end
    if (bus_wr) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (be_i[b]) begin
          mem_q[bus_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: three instances (default, grant wait states,
// deep response latency) driven from shared address/data and backdoor inputs.
module tb_obi_mem_responder;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic        req_a, req_b, req_c;
  logic [31:0] addr, wdata, bd_addr, bd_wdata;
  logic        we, bd_we;
  logic [3:0]  be;

  logic        gnt_a, gnt_b, gnt_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic        err_a, err_b, err_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;

  int total;
  int bad;

  obi_mem_responder u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a),
    .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata)
  );

  obi_mem_responder #(.GNT_LATENCY(3), .RSP_LATENCY(2)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b),
    .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata)
  );

  obi_mem_responder #(.RSP_LATENCY(4), .MAX_OUTSTANDING(2)) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(req_c), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt_c), .rvalid_o(rvalid_c), .rdata_o(rdata_c), .err_o(err_c),
    .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
    bd_we = 1'b1;
    bd_addr = a;
    bd_wdata = d;
    tick();
    bd_we = 1'b0;
  endtask

  // One single-beat transaction on instance A; returns what was observed.
  task automatic a_xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic g, output logic rv,
                        output logic e, output logic [31:0] rd);
    req_a = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    g = gnt_a;
    tick();
    req_a = 1'b0; we = 1'b0;
    @(negedge clk);
    rv = rvalid_a; e = err_a; rd = rdata_a;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; req_c = 1'b1; addr = '0; we = 1'b0;
    tick();
    @(negedge clk);
    total++; if (gnt_a !== 1'b0) begin bad++; $display("FAIL reset_gnt_a: got %b want 0", gnt_a); end
    total++; if (gnt_c !== 1'b0) begin bad++; $display("FAIL reset_gnt_c: got %b want 0", gnt_c); end
    total++;
    if ({rvalid_a, rvalid_b, rvalid_c} !== 3'b000) begin
      bad++; $display("FAIL reset_rvalid: got %b want 000", {rvalid_a, rvalid_b, rvalid_c});
    end
    total++; if (rdata_a !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_a); end
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    tick();
  endtask

  task automatic test_preload_read();
    logic g, rv, e;
    logic [31:0] rd;
    bd_write(32'h0, 32'hDEAD_BEEF);
    a_xact(1'b0, 32'h0, 32'h0, 4'hF, g, rv, e, rd);
    total++; if (g !== 1'b1) begin bad++; $display("FAIL preload_gnt: got %b want 1", g); end
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL preload_rvalid: got %b want 1", rv); end
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL preload_rdata: got %h want deadbeef", rd); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL preload_err: got %b want 0", e); end
  endtask

  task automatic test_byte_write();
    logic g, rv, e;
    logic [31:0] rd;
    bd_write(32'h4, 32'hFFFF_FFFF);
    a_xact(1'b1, 32'h4, 32'h1122_3344, 4'b0101, g, rv, e, rd);
    total++; if (g !== 1'b1) begin bad++; $display("FAIL bw_gnt: got %b want 1", g); end
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL bw_rvalid: got %b want 1", rv); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL bw_wr_rdata: got %h want 0", rd); end
    a_xact(1'b0, 32'h4, 32'h0, 4'hF, g, rv, e, rd);
    total++; if (rd !== 32'hFF22_FF44) begin bad++; $display("FAIL bw_readback: got %h want ff22ff44", rd); end
  endtask

  task automatic test_grant_latency();
    logic exp_gnt, exp_rv;
    req_b = 1'b1; addr = 32'h0; we = 1'b0; be = 4'hF;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) req_b = 1'b0;
      @(negedge clk);
      exp_gnt = (k == 3);
      exp_rv  = (k == 5);
      total++;
      if (gnt_b !== exp_gnt) begin bad++; $display("FAIL glat_gnt c%0d: got %b want %b", k, gnt_b, exp_gnt); end
      total++;
      if (rvalid_b !== exp_rv) begin bad++; $display("FAIL glat_rvalid c%0d: got %b want %b", k, rvalid_b, exp_rv); end
      if (exp_rv) begin
        total++;
        if (rdata_b !== 32'hDEAD_BEEF) begin bad++; $display("FAIL glat_rdata: got %h want deadbeef", rdata_b); end
      end
      tick();
    end
  endtask

  task automatic test_outstanding();
    int due[$];
    int live;
    logic exp_rv, exp_gnt;
    live = 0;
    addr = 32'h0; we = 1'b0; be = 4'hF;
    for (int k = 0; k < 16; k++) begin
      req_c = (k < 10);
      @(negedge clk);
      exp_rv  = (due.size() > 0) && (due[0] == k);
      exp_gnt = req_c && ((due.size() - int'(exp_rv)) < 2);
      total++;
      if (gnt_c !== exp_gnt) begin bad++; $display("FAIL out_gnt c%0d: got %b want %b", k, gnt_c, exp_gnt); end
      total++;
      if (rvalid_c !== exp_rv) begin bad++; $display("FAIL out_rvalid c%0d: got %b want %b", k, rvalid_c, exp_rv); end
      if (exp_rv) begin
        total++;
        if (rdata_c !== 32'hDEAD_BEEF) begin bad++; $display("FAIL out_rdata c%0d: got %h want deadbeef", k, rdata_c); end
        void'(due.pop_front());
      end
      if (exp_gnt) due.push_back(k + 4);
      live = live + int'(gnt_c === 1'b1) - int'(rvalid_c === 1'b1);
      total++;
      if (live > 2) begin bad++; $display("FAIL out_limit c%0d: got %0d want <=2", k, live); end
      tick();
    end
    req_c = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic g, rv, e;
    logic [31:0] rd;
    a_xact(1'b0, 32'h1000, 32'h0, 4'hF, g, rv, e, rd);
    total++; if (g !== 1'b1) begin bad++; $display("FAIL oor_gnt: got %b want 1", g); end
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL oor_rvalid: got %b want 1", rv); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_err: got %b want 1", e); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rdata: got %h want 0", rd); end
    a_xact(1'b1, 32'h1000, 32'h0BAD_0BAD, 4'hF, g, rv, e, rd);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_wr_err: got %b want 1", e); end
    a_xact(1'b0, 32'h0, 32'h0, 4'hF, g, rv, e, rd);
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL oor_alias: got %h want deadbeef", rd); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL oor_alias_err: got %b want 0", e); end
  endtask

  task automatic test_reset_inflight();
    logic exp_gnt, exp_rv;
    addr = 32'h0; we = 1'b0; be = 4'hF; req_c = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (gnt_c !== 1'b1) begin bad++; $display("FAIL rif_gnt c%0d: got %b want 1", k, gnt_c); end
      tick();
    end
    req_c = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      total++; if (rvalid_c !== 1'b0) begin bad++; $display("FAIL rif_dropped c%0d: got %b want 0", k, rvalid_c); end
      tick();
    end
    // A freshly reset counter admits two back-to-back grants again.
    for (int k = 0; k < 8; k++) begin
      req_c = (k < 2);
      exp_gnt = (k < 2);
      exp_rv  = (k == 4) || (k == 5);
      @(negedge clk);
      total++;
      if (gnt_c !== exp_gnt) begin bad++; $display("FAIL rif_regnt c%0d: got %b want %b", k, gnt_c, exp_gnt); end
      total++;
      if (rvalid_c !== exp_rv) begin bad++; $display("FAIL rif_rvalid c%0d: got %b want %b", k, rvalid_c, exp_rv); end
      if (exp_rv) begin
        total++;
        if (rdata_c !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rif_rdata c%0d: got %h want deadbeef", k, rdata_c); end
      end
      tick();
    end
    req_c = 1'b0;
  endtask

  task automatic test_random_traffic();
    logic [31:0] ref_mem [16];
    rsp_t q[$];
    rsp_t r;
    logic exp_rv, exp_gnt, in_rng;
    int idx;
    for (int w = 0; w < 16; w++) begin
      ref_mem[w] = $urandom;
      bd_write(32'(w * 4), ref_mem[w]);
    end
    for (int k = 0; k <= 300; k++) begin
      req_a = (k < 300) && ($urandom_range(0, 99) < 70);
      we = 1'($urandom_range(0, 1)); be = 4'($urandom); wdata = $urandom;
      case ($urandom_range(0, 9))
        0:       addr = 32'h1000 + 32'($urandom_range(0, 4095));
        1:       addr = 32'hFFFF_FFFC;
        default: addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      endcase
      bd_we = (k < 300) && !req_a && ($urandom_range(0, 3) == 0);
      bd_addr = 32'($urandom_range(0, 15) * 4);
      bd_wdata = $urandom;
      @(negedge clk);
      exp_rv  = (q.size() > 0) && (q[0].due == k);
      exp_gnt = req_a && ((q.size() - int'(exp_rv)) < 2);
      total++;
      if (gnt_a !== exp_gnt) begin bad++; $display("FAIL rnd_gnt c%0d: got %b want %b", k, gnt_a, exp_gnt); end
      total++;
      if (rvalid_a !== exp_rv) begin bad++; $display("FAIL rnd_rvalid c%0d: got %b want %b", k, rvalid_a, exp_rv); end
      if (exp_rv) begin
        r = q.pop_front();
        total++;
        if (err_a !== r.err) begin bad++; $display("FAIL rnd_err c%0d: got %b want %b", k, err_a, r.err); end
        total++;
        if (rdata_a !== r.data) begin bad++; $display("FAIL rnd_rdata c%0d: got %h want %h", k, rdata_a, r.data); end
      end
      if (exp_gnt) begin
        in_rng = (addr < 32'h1000);
        idx = int'(addr[5:2]);
        r.due = k + 1;
        r.err = !in_rng;
        r.data = (in_rng && !we) ? ref_mem[idx] : 32'h0;
        q.push_back(r);
        if (in_rng && we) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
          end
        end
      end
      if (bd_we) ref_mem[int'(bd_addr[5:2])] = bd_wdata;
      tick();
    end
    req_a = 1'b0; bd_we = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    addr = '0; we = 1'b0; be = 4'hF; wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    test_reset();
    test_preload_read();
    test_byte_write();
    test_grant_latency();
    test_outstanding();
    test_out_of_range();
    test_reset_inflight();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
